// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: writeback payload type, core sizing constants and pointer-width helper
package cdb_arbiter_pkg;
  localparam int NUM_FU = 4;
  localparam int NUM_CDB = 2;
  localparam int ROB_IDX_W = 4;
  localparam int XLEN = 32;
  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } rob_wb_t;
  localparam int ROB_WB_WIDTH = $bits(rob_wb_t);
  function automatic int ptr_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU result handshake and CDB broadcast bundle
// master (FUs): drives fu_valid/fu_data, sees fu_ready, cdb, cdb_busy
// slave (arbiter): the reverse
interface cdb_arbiter_if #(
  parameter int NUM_REQ  = cdb_arbiter_pkg::NUM_FU,
  parameter int NUM_CDB  = cdb_arbiter_pkg::NUM_CDB,
  parameter int WB_WIDTH = cdb_arbiter_pkg::ROB_WB_WIDTH
);
  logic [NUM_REQ-1:0]               fu_valid;
  logic [NUM_REQ-1:0][WB_WIDTH-1:0] fu_data;
  logic [NUM_REQ-1:0]               fu_ready;
  logic [NUM_CDB-1:0][WB_WIDTH-1:0] cdb;
  logic [NUM_REQ-1:0]               cdb_busy;
  modport master (output fu_valid, fu_data, input fu_ready, cdb, cdb_busy);
  modport slave (input fu_valid, fu_data, output fu_ready, cdb, cdb_busy);
endinterface

// File: rtl/cdb_arbiter_rr_multi_grant.sv
// rr_multi_grant: circular scan from ptr granting up to C occupied entries, k-th grant to slot k
// occ/ptr in; grant vector, per-slot one-hot sel and next start pointer out
module rr_multi_grant
  import cdb_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int C = 2
) (
  input  logic [N-1:0]            occ,
  input  logic [ptr_w(N)-1:0]     ptr,
  output logic [N-1:0]            grant,
  output logic [C-1:0][N-1:0]     sel,
  output logic [ptr_w(N)-1:0]     ptr_n
);
  localparam int PW = ptr_w(N);
  localparam int CW = $clog2(C + 1);
  logic [PW-1:0] idx;
  logic [CW-1:0] cnt;
  always_comb begin
    grant = '0;
    sel = '0;
    ptr_n = ptr;
    idx = ptr;
    cnt = '0;
    for (int k = 0; k < N; k++) begin
      if (occ[idx] && cnt < CW'(C)) begin
        grant[idx] = 1'b1;
        for (int s = 0; s < C; s++) if (cnt == CW'(s)) sel[s][idx] = 1'b1;
        cnt = cnt + 1'b1;
        ptr_n = idx == PW'(N - 1) ? '0 : idx + 1'b1;
      end
      idx = idx == PW'(N - 1) ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU one-entry holding registers drained round-robin onto NUM_CDB registered CDB slots
// clk_i/reset_i: clock, sync active-high reset; flush_i: mispredict flush (discards all pending)
// bus: FU valid/ready/data in, registered cdb slots and holding-register occupancy out
module cdb_arbiter #(
  parameter int NUM_REQ  = cdb_arbiter_pkg::NUM_FU,
  parameter int NUM_CDB  = cdb_arbiter_pkg::NUM_CDB,
  parameter int WB_WIDTH = cdb_arbiter_pkg::ROB_WB_WIDTH
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  cdb_arbiter_if.slave bus
);
  localparam int PW = cdb_arbiter_pkg::ptr_w(NUM_REQ);
  logic [NUM_REQ-1:0]               occ, grant, ready, xfer;
  logic [NUM_REQ-1:0][WB_WIDTH-1:0] hold;
  logic [NUM_CDB-1:0][NUM_REQ-1:0]  sel;
  logic [NUM_CDB-1:0][WB_WIDTH-1:0] cdb_q, cdb_d;
  logic [PW-1:0]                    rr_ptr, rr_ptr_n;
  rr_multi_grant #(.N(NUM_REQ), .C(NUM_CDB)) u_grant (
    .occ(occ),
    .ptr(rr_ptr),
    .grant(grant),
    .sel(sel),
    .ptr_n(rr_ptr_n)
  );
  // a granted entry frees up this cycle, so it can reload back-to-back
  assign ready = {NUM_REQ{~(reset_i | flush_i)}} & (~occ | grant);
  assign xfer = bus.fu_valid & ready;
  assign bus.fu_ready = ready;
  assign bus.cdb = cdb_q;
  assign bus.cdb_busy = occ;
  always_comb begin
    cdb_d = '0;
    for (int s = 0; s < NUM_CDB; s++)
      for (int i = 0; i < NUM_REQ; i++)
        if (sel[s][i]) cdb_d[s] = cdb_d[s] | hold[i];
  end
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      occ <= '0;
      rr_ptr <= '0;
      cdb_q <= '0;
    end else begin
      occ <= (occ & ~grant) | xfer;
      rr_ptr <= rr_ptr_n;
      cdb_q <= cdb_d;
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) if (xfer[i]) hold[i] <= bus.fu_data[i];
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven cycle vectors plus per-FU payload scoreboard for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
  typedef struct packed {
    logic       flush;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [3:0] busy;
    logic [2:0] s0;
    logic [2:0] s1;
  } vec_t;
  localparam logic [2:0] E = 3'd7;
  localparam int NV = 37;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int checks = 0;
  int failures = 0;
  int seq [4];
  rob_wb_t q [4][$];
  vec_t tbl [NV];
  cdb_arbiter_if #(.NUM_REQ(4), .NUM_CDB(2), .WB_WIDTH(ROB_WB_WIDTH)) bus ();
  cdb_arbiter #(.NUM_REQ(4), .NUM_CDB(2), .WB_WIDTH(ROB_WB_WIDTH)) dut (
    .clk_i(clk),
    .reset_i(rst),
    .flush_i(flush),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic rob_wb_t mk(int f, int s);
    rob_wb_t w;
    w.valid = 1'b1;
    w.idx = ROB_IDX_W'(f);
    w.data = {8'(f), 24'(s)};
    return w;
  endfunction
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic chk_slot(int r, int s, logic [2:0] e);
    rob_wb_t exp;
    int f;
    exp = '0;
    f = int'(e);
    if (e != E) begin
      if (q[f].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL r%0d_slot%0d: scoreboard empty for fu %0d, got %h", r, s, f, bus.cdb[s]);
        return;
      end
      exp = q[f].pop_front();
    end
    chk($sformatf("r%0d_slot%0d", r, s), 64'(bus.cdb[s]), 64'(exp));
  endtask
  task automatic drive_data();
    for (int i = 0; i < 4; i++) bus.fu_data[i] = mk(i, seq[i]);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    tbl = '{
      '{1'b0, 4'b1000, 4'b1111, 4'b0000, E, E},
      '{1'b0, 4'b1000, 4'b1111, 4'b1000, E, E},
      '{1'b0, 4'b1000, 4'b1111, 4'b1000, 3'd3, E},
      '{1'b0, 4'b1000, 4'b1111, 4'b1000, 3'd3, E},
      '{1'b0, 4'b0000, 4'b1111, 4'b1000, 3'd3, E},
      '{1'b0, 4'b0000, 4'b1111, 4'b0000, 3'd3, E},
      '{1'b0, 4'b0000, 4'b1111, 4'b0000, E, E},
      '{1'b0, 4'b1111, 4'b1111, 4'b0000, E, E},
      '{1'b0, 4'b1111, 4'b0011, 4'b1111, E, E},
      '{1'b0, 4'b1111, 4'b1100, 4'b1111, 3'd0, 3'd1},
      '{1'b0, 4'b1111, 4'b0011, 4'b1111, 3'd2, 3'd3},
      '{1'b0, 4'b1111, 4'b1100, 4'b1111, 3'd0, 3'd1},
      '{1'b0, 4'b0000, 4'b0011, 4'b1111, 3'd2, 3'd3},
      '{1'b0, 4'b0000, 4'b1111, 4'b1100, 3'd0, 3'd1},
      '{1'b0, 4'b0000, 4'b1111, 4'b0000, 3'd2, 3'd3},
      '{1'b0, 4'b0000, 4'b1111, 4'b0000, E, E},
      '{1'b0, 4'b0100, 4'b1111, 4'b0000, E, E},
      '{1'b0, 4'b1011, 4'b1111, 4'b0100, E, E},
      '{1'b0, 4'b0000, 4'b1101, 4'b1011, 3'd2, E},
      '{1'b0, 4'b0000, 4'b1111, 4'b0010, 3'd3, 3'd0},
      '{1'b0, 4'b0000, 4'b1111, 4'b0000, 3'd1, E},
      '{1'b0, 4'b0000, 4'b1111, 4'b0000, E, E},
      '{1'b0, 4'b1111, 4'b1111, 4'b0000, E, E},
      '{1'b0, 4'b1100, 4'b1100, 4'b1111, E, E},
      '{1'b1, 4'b0100, 4'b0000, 4'b1111, 3'd2, 3'd3},
      '{1'b0, 4'b1111, 4'b1111, 4'b0000, E, E},
      '{1'b0, 4'b0000, 4'b0011, 4'b1111, E, E},
      '{1'b0, 4'b0000, 4'b1111, 4'b1100, 3'd0, 3'd1},
      '{1'b0, 4'b0000, 4'b1111, 4'b0000, 3'd2, 3'd3},
      '{1'b0, 4'b0000, 4'b1111, 4'b0000, E, E},
      '{1'b0, 4'b0010, 4'b1111, 4'b0000, E, E},
      '{1'b0, 4'b1110, 4'b1111, 4'b0010, E, E},
      '{1'b0, 4'b0010, 4'b1101, 4'b1110, 3'd1, E},
      '{1'b0, 4'b0010, 4'b1111, 4'b0010, 3'd2, 3'd3},
      '{1'b0, 4'b0000, 4'b1111, 4'b0010, 3'd1, E},
      '{1'b0, 4'b0000, 4'b1111, 4'b0000, 3'd1, E},
      '{1'b0, 4'b0000, 4'b1111, 4'b0000, E, E}
    };
    for (int i = 0; i < 4; i++) seq[i] = 0;
    rst = 1'b1;
    bus.fu_valid = 4'b1111;
    drive_data();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("reset%0d_ready", c), 64'(bus.fu_ready), 64'(4'b0000));
      chk($sformatf("reset%0d_busy", c), 64'(bus.cdb_busy), 64'(4'b0000));
      chk($sformatf("reset%0d_cdb", c), 64'(bus.cdb), 64'd0);
    end
    rst = 1'b0;
    for (int r = 0; r < NV; r++) begin
      flush = tbl[r].flush;
      bus.fu_valid = tbl[r].valid;
      drive_data();
      #1;
      chk($sformatf("r%0d_ready", r), 64'(bus.fu_ready), 64'(tbl[r].ready));
      chk($sformatf("r%0d_busy", r), 64'(bus.cdb_busy), 64'(tbl[r].busy));
      chk_slot(r, 0, tbl[r].s0);
      chk_slot(r, 1, tbl[r].s1);
      if (tbl[r].flush) begin
        for (int i = 0; i < 4; i++) q[i].delete();
      end else begin
        for (int i = 0; i < 4; i++)
          if (tbl[r].valid[i] && tbl[r].ready[i]) begin
            q[i].push_back(mk(i, seq[i]));
            seq[i]++;
          end
      end
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    chk("drain_sb", 64'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 64'd0);
    bus.fu_valid = 4'b1111;
    drive_data();
    #1;
    chk("midrst_pre_ready", 64'(bus.fu_ready), 64'(4'b1111));
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.fu_valid = 4'b0000;
    #1;
    chk("midrst_busy_before", 64'(bus.cdb_busy), 64'(4'b1111));
    chk("midrst_ready", 64'(bus.fu_ready), 64'(4'b0000));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.cdb_busy), 64'(4'b0000));
    chk("midrst_cdb", 64'(bus.cdb), 64'd0);
    chk("midrst_ready_after", 64'(bus.fu_ready), 64'(4'b1111));
    @(posedge clk);
    #1;
    chk("midrst_cdb_next", 64'(bus.cdb), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
